// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I pipeline front end.
//   XLEN          : architectural register / address width
//   NOP_INSN      : canonical bubble encoding (addi x0, x0, 0)
//   fetch_state_t : fetch-stage sequencer states
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    // FETCH : request to imem is presented
    // WAIT  : one request outstanding, response will be used
    // FULL  : response captured in the skid buffer, decode is stalled
    // DROP  : one request outstanding whose response must be discarded
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register between fetch and decode.
//   clk, rst        : clock, synchronous active-high reset
//   load            : a fetched instruction is delivered this cycle
//   stall           : decode cannot advance, hold current contents
//   flush           : squash contents to a bubble (wins over stall)
//   load_insn/pc    : instruction and its PC to capture when load is high
//   instruction_d1  : registered instruction to decode
//   pc_d            : registered PC to decode
//   valid_d         : register holds a real instruction
// Priority: rst/flush > stall > load > bubble.
// ---------------------------------------------------------------------------
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSN = NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] load_insn,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] instruction_d1,
    output logic [XLEN-1:0] pc_d,
    output logic            valid_d
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instruction_d1 <= BUBBLE_INSN;
            pc_d           <= '0;
            valid_d        <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instruction_d1 <= load_insn;
                pc_d           <= load_pc;
                valid_d        <= 1'b1;
            end else begin
                // Decode advanced and nothing new arrived: insert a bubble so
                // the same instruction is never issued twice.
                instruction_d1 <= BUBBLE_INSN;
                pc_d           <= '0;
                valid_d        <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the fetch PC,
// issues one instruction-memory request at a time, and feeds the IF/ID
// register that decode reads. Decode stalls are absorbed by a one-entry skid
// buffer; EX redirects squash the IF/ID register, the skid buffer and any
// request still in flight.
//
// Parameters
//   RESET_PC        : fetch PC loaded on reset
//   NOP_INSN        : bubble encoding driven on instruction_d1 when empty
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   imem_req_valid  : request valid (from registered state only)
//   imem_req_ready  : memory accepts the request this cycle
//   imem_req_addr   : word-aligned fetch address
//   imem_rsp_valid  : response data valid
//   imem_rsp_data   : returned instruction
//   stall_d         : decode cannot advance, IF/ID holds
//   redirect_valid  : control-flow change from EX (highest priority)
//   redirect_pc     : new fetch target, low two bits forced to zero
//   instruction_d1  : IF/ID instruction
//   pc_d            : IF/ID PC
//   valid_d         : IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall_d,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instruction_d1,
    output logic [XLEN-1:0] pc_d,
    output logic            valid_d
);

    fetch_state_t    state;
    fetch_state_t    state_next;

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] buf_insn;
    logic [XLEN-1:0] buf_pc;
    logic            buf_valid;

    logic            req_fire;
    logic            rsp_take;
    logic            deliver_rsp;
    logic            deliver_buf;
    logic            capture_buf;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_insn;
    logic [XLEN-1:0] ifid_pc;
    logic            in_flight_next;

    // Request channel: valid depends only on the registered state, so the
    // address (pc_f) cannot move until the handshake completes or EX
    // redirects. rst masks it because state is meaningless until reset lands.
    assign imem_req_valid = (state == FETCH) && !rst;
    assign imem_req_addr  = pc_f;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is only meaningful in WAIT; in DROP it is swallowed.
    assign rsp_take    = (state == WAIT) && imem_rsp_valid;
    assign deliver_rsp = rsp_take && !stall_d && !redirect_valid;
    assign capture_buf = rsp_take && stall_d && !redirect_valid;
    assign deliver_buf = (state == FULL) && buf_valid && !stall_d && !redirect_valid;

    assign ifid_load = deliver_rsp || deliver_buf;
    assign ifid_insn = deliver_buf ? buf_insn : imem_rsp_data;
    assign ifid_pc   = deliver_buf ? buf_pc   : req_pc;

    // After a redirect edge a request is still outstanding if the one we were
    // waiting on has not come back yet, or one is being accepted right now.
    assign in_flight_next = (((state == WAIT) || (state == DROP)) && !imem_rsp_valid)
                            || req_fire;

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = in_flight_next ? DROP : FETCH;
        end else begin
            case (state)
                FETCH: if (req_fire)       state_next = WAIT;
                WAIT:  if (imem_rsp_valid) state_next = stall_d ? FULL : FETCH;
                FULL:  if (!stall_d)       state_next = FETCH;
                DROP:  if (imem_rsp_valid) state_next = FETCH;
                default:                   state_next = FETCH;
            endcase
        end
    end

    // Control state: sequencer, fetch PC, skid-buffer occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc_f      <= RESET_PC;
            buf_valid <= 1'b0;
        end else begin
            state <= state_next;

            if (redirect_valid) begin
                pc_f <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                pc_f <= pc_f + 32'd4;
            end

            if (redirect_valid || deliver_buf) begin
                buf_valid <= 1'b0;
            end else if (capture_buf) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Data-only registers; their contents are qualified by state/buf_valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_pc <= pc_f;
        end
        if (capture_buf) begin
            buf_insn <= imem_rsp_data;
            buf_pc   <= req_pc;
        end
    end

    // IF/ID boundary
    if_id_reg #(
        .BUBBLE_INSN (NOP_INSN)
    ) u_if_id_reg (
        .clk            (clk),
        .rst            (rst),
        .load           (ifid_load),
        .stall          (stall_d),
        .flush          (redirect_valid),
        .load_insn      (ifid_insn),
        .load_pc        (ifid_pc),
        .instruction_d1 (instruction_d1),
        .pc_d           (pc_d),
        .valid_d        (valid_d)
    );

    // Only one request may be outstanding, so a response outside WAIT/DROP
    // means the memory broke protocol.
    a_rsp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((state == WAIT) || (state == DROP))
    );

    // A presented request keeps valid and address until accepted or redirected.
    a_req_stable: assert property (
        @(posedge clk) disable iff (rst)
        (imem_req_valid && !imem_req_ready && !redirect_valid)
        |=> (imem_req_valid && $stable(imem_req_addr))
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of `decode_stage` and drives its `instruction_d1` and `pc_d` inputs through the IF/ID pipeline register. Owns the fetch PC and issues one request at a time to instruction memory over a valid/ready request channel with a response-valid return. Honours decode stalls from the hazard unit and branch/jump redirects from EX, squashing wrong-path instructions, including requests still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch PC loaded on reset
- `NOP_INSN`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) driven on `instruction_d1` when empty

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response data valid
- `imem_rsp_data`  in  32  returned instruction
- `stall_d`  in  1  hold IF/ID contents (decode cannot advance)
- `redirect_valid`  in  1  control-flow change from EX
- `redirect_pc`  in  32  new fetch target; bits [1:0] ignored, forced 0
- `instruction_d1`  out  32  IF/ID instruction to decode
- `pc_d`  out  32  IF/ID PC to decode
- `valid_d`  out  1  IF/ID holds a real instruction

## Operation
- Registers: `pc_f`, `req_pc` (PC of outstanding request), one-entry skid buffer (`buf_insn`, `buf_pc`, `buf_valid`), IF/ID (`instruction_d1`, `pc_d`, `valid_d`), FSM state.
- FSM states: FETCH, WAIT, FULL, DROP.
- FETCH: `imem_req_valid`=1, `imem_req_addr`=`pc_f`. On `imem_req_ready`: `req_pc`<=`pc_f`, `pc_f`<=`pc_f`+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go WAIT.
- WAIT: on `imem_rsp_valid`: if `!stall_d`, load IF/ID with {rsp_data, `req_pc`, 1} and go FETCH; else load skid buffer and go FULL.
- FULL: no request. When `!stall_d`, move buffer into IF/ID, clear `buf_valid`, go FETCH.
- DROP: no request. On `imem_rsp_valid`, discard data and go FETCH.
- IF/ID with `!stall_d` and nothing delivered that cycle: load bubble (`NOP_INSN`, `pc_d`=0, `valid_d`=0). With `stall_d`, IF/ID holds.
- Redirect has highest priority, overrides `stall_d`: `pc_f`<={redirect_pc[31:2],2'b00}; IF/ID flushed to bubble; `buf_valid`<=0. Next state: DROP if a request is outstanding after this edge (state WAIT without `imem_rsp_valid`, or FETCH with `imem_req_ready`); otherwise FETCH (includes WAIT with simultaneous response, which is discarded).
- `imem_req_valid` depends on registered state only; once asserted, it is held, and the address is held stable, until `imem_req_ready`, unless a redirect occurs.
- At most one outstanding request; responses arriving in FETCH or FULL are a protocol error (ignored, assertion flagged).

## Timing
- Reset: state FETCH, `pc_f`=`RESET_PC`, `instruction_d1`=`NOP_INSN`, `pc_d`=0, `valid_d`=0, `buf_valid`=0; `imem_req_valid`=0 while `rst` is high.
- Zero-wait memory (ready in cycle N, response in N+1): instruction is visible on IF/ID in cycle N+2; throughput one instruction per 2 cycles.
- Redirect in cycle N: IF/ID is a bubble in N+1; the first request to the target is issued in N+1 (or the cycle after the dropped response arrives).
- Reset mid-operation overrides everything, including in-flight requests; a response for a pre-reset request that arrives after reset is ignored in FETCH.

## Structure
- Shared package `riscv_pkg`: `NOP_INSN` constant, `fetch_state_t` enum, `XLEN`=32.
- One natural sub-module: `if_id_reg`, the IF/ID register with load/stall/flush inputs.

## Test plan
- Reset, ready=1, response one cycle later with 0x00500093 → at cycle 3, `instruction_d1`=0x00500093, `pc_d`=0, `valid_d`=1; next request address is 0x4.
- `imem_req_ready` low for 3 cycles in FETCH → `imem_req_valid` and address 0x0 are held stable; `pc_f` advances only on the accept cycle.
- `stall_d` high when the response arrives → state FULL, IF/ID unchanged, no request issued; drop `stall_d` → buffered instruction appears with its PC.
- Redirect to 0x103 while in WAIT, old response 2 cycles later → state DROP, response discarded, `valid_d`=0, next request address 0x100.
- Redirect in the same cycle as `imem_rsp_valid` with `stall_d`=1 → IF/ID flushed to `NOP_INSN`/`valid_d`=0, response discarded, state FETCH at the new target.
- `RESET_PC`=0xFFFF_FFFC, fetch one instruction → following request address wraps to 0x0.
